// File: rtl/step5_normalize_round.sv
// Purpose: normalize, round-to-nearest-even and pack the MAC accumulator into an IEEE-754 word.
// Latency: 2 cycles from input accept to out_valid, 1 beat/cycle sustained.
// Backpressure: elastic 2-entry pipe; in_ready = !vA | !vB | out_ready, outputs held while stalled.
//
// Ports:
//   clock, resetn             rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready       input handshake
//   in_sign, in_ov_sign       result sign, upstream overflow (forces +/-inf)
//   in_exp  [EXP_W+2]         signed biased exponent of bit SUM_W-2 of in_sum
//   in_sum  [SUM_W]           {carry, hidden, fraction, G, R, S} raw magnitude
//   out_valid / out_ready     output handshake
//   out_result                packed {sign, exp, frac}
//   out_overflow/underflow/zero  exception flags
//
// Build option: define STEP5_DENORM_EN to produce subnormals instead of flushing tiny results.
module step5_normalize_round #(
   parameter int MANT_W = 24,
   parameter int SUM_W  = 28,
   parameter int EXP_W  = 8
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_sign,
   input  logic                      in_ov_sign,
   input  logic [EXP_W+1:0]          in_exp,
   input  logic [SUM_W-1:0]          in_sum,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [EXP_W+MANT_W-1:0]   out_result,
   output logic                      out_overflow,
   output logic                      out_underflow,
   output logic                      out_zero
);

   localparam int NW     = SUM_W - 1;          // normalized vector: hidden .. S
   localparam int EW     = EXP_W + 2;
   localparam int LZW    = $clog2(NW + 1);
   localparam int SH_MAX = MANT_W + 2;
   localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

   // ---------------- handshake ----------------
   logic r_va, r_vb;
   logic w_b_adv, w_a_load;

   assign w_b_adv  = !r_vb || out_ready;
   assign in_ready = !r_va || !r_vb || out_ready;
   assign w_a_load = in_valid && in_ready;

   // ---------------- stage A: normalize ----------------
   logic [LZW-1:0] w_lzc;
   logic           w_found;
   logic           w_zero;
   logic [NW-1:0]  w_norm;
   logic [EW-1:0]  w_exp;

   always_comb begin
      w_lzc   = '0;
      w_found = 1'b0;
      for (int i = NW - 1; i >= 0; i--) begin
         if (!w_found) begin
            if (in_sum[i]) w_found = 1'b1;
            else           w_lzc   = w_lzc + 1'b1;
         end
      end
   end

   always_comb begin
      w_zero = (in_sum == '0);
      if (in_sum[SUM_W-1]) begin
         // carry: one right shift, dropped bit folds into sticky
         w_norm = {in_sum[SUM_W-1:2], in_sum[1] | in_sum[0]};
         w_exp  = in_exp + EW'(1);
      end else begin
         w_norm = in_sum[NW-1:0] << w_lzc;
         w_exp  = in_exp - EW'(w_lzc);
      end
   end

   logic          r_a_sign, r_a_ov, r_a_zero;
   logic [EW-1:0] r_a_exp;
   logic [NW-1:0] r_a_norm;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_va     <= 1'b0;
         r_a_sign <= 1'b0;
         r_a_ov   <= 1'b0;
         r_a_zero <= 1'b0;
         r_a_exp  <= '0;
         r_a_norm <= '0;
      end else begin
         if (w_a_load)     r_va <= 1'b1;
         else if (w_b_adv) r_va <= 1'b0;
         if (w_a_load) begin
            r_a_sign <= in_sign;
            r_a_ov   <= in_ov_sign;
            r_a_zero <= w_zero;
            r_a_exp  <= w_exp;
            r_a_norm <= w_norm;
         end
      end
   end

   // ---------------- stage B: round ----------------
   logic [MANT_W-1:0] w_mant;
   logic              w_rup;
   logic [MANT_W:0]   w_mant_r;
   logic [MANT_W-2:0] w_frac;
   logic [EW-1:0]     w_exp_r;

   always_comb begin
      w_mant   = r_a_norm[NW-1:3];
      w_rup    = r_a_norm[2] && (r_a_norm[1] || r_a_norm[0] || r_a_norm[3]);
      w_mant_r = {1'b0, w_mant} + (MANT_W+1)'(w_rup);
      if (w_mant_r[MANT_W]) begin
         // rounded up past 1.111..: mantissa becomes 1.0, bump exponent
         w_frac  = '0;
         w_exp_r = r_a_exp + EW'(1);
      end else begin
         w_frac  = w_mant_r[MANT_W-2:0];
         w_exp_r = r_a_exp;
      end
   end

`ifdef STEP5_DENORM_EN
   // Subnormal path: shift right by 1-exp (capped), keep sticky, round again.
   logic [EW-1:0]     w_sh_full;
   logic [LZW-1:0]    w_sh;
   logic              w_sticky;
   logic [NW-1:0]     w_dn;
   logic              w_dn_rup;
   logic [MANT_W:0]   w_dn_r;

   always_comb begin
      w_sh_full = EW'(1) - r_a_exp;
      if (w_sh_full > EW'(SH_MAX)) w_sh = LZW'(SH_MAX);
      else                         w_sh = w_sh_full[LZW-1:0];
      w_sticky = 1'b0;
      for (int i = 0; i < NW; i++) begin
         if (i < int'(w_sh)) w_sticky = w_sticky | r_a_norm[i];
      end
      w_dn     = r_a_norm >> w_sh;
      w_dn[0]  = w_dn[0] | w_sticky;
      w_dn_rup = w_dn[2] && (w_dn[1] || w_dn[0] || w_dn[3]);
      w_dn_r   = {1'b0, w_dn[NW-1:3]} + (MANT_W+1)'(w_dn_rup);
   end
`endif

   // ---------------- stage B: pack ----------------
   logic [EXP_W+MANT_W-1:0] w_res;
   logic                    w_ov, w_uf, w_zf;

   always_comb begin
      w_res = '0;
      w_ov  = 1'b0;
      w_uf  = 1'b0;
      w_zf  = 1'b0;
      if (r_a_ov) begin
         w_res = {r_a_sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
         w_ov  = 1'b1;
      end else if ($signed(w_exp_r) >= $signed(EXP_MAX)) begin
         w_res = {r_a_sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
         w_ov  = 1'b1;
      end else if (r_a_zero) begin
         w_zf  = 1'b1;
      end else if ($signed(r_a_exp) <= 0) begin
`ifdef STEP5_DENORM_EN
         // rounding into the hidden position yields the smallest normal
         w_res = {r_a_sign, EXP_W'(w_dn_r[MANT_W-1]), w_dn_r[MANT_W-2:0]};
         w_uf  = |w_dn[2:0];
         w_zf  = (w_dn_r == '0);
`else
         w_res = {r_a_sign, {(EXP_W+MANT_W-1){1'b0}}};
         w_uf  = 1'b1;
         w_zf  = 1'b1;
`endif
      end else begin
         w_res = {r_a_sign, w_exp_r[EXP_W-1:0], w_frac};
      end
   end

   logic [EXP_W+MANT_W-1:0] r_result;
   logic                    r_ov, r_uf, r_zf;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_vb     <= 1'b0;
         r_result <= '0;
         r_ov     <= 1'b0;
         r_uf     <= 1'b0;
         r_zf     <= 1'b0;
      end else if (w_b_adv) begin
         r_vb <= r_va;
         if (r_va) begin
            r_result <= w_res;
            r_ov     <= w_ov;
            r_uf     <= w_uf;
            r_zf     <= w_zf;
         end
      end
   end

   assign out_valid     = r_vb;
   assign out_result    = r_result;
   assign out_overflow  = r_ov;
   assign out_underflow = r_uf;
   assign out_zero      = r_zf;

endmodule

// File: tb/tb_step5_normalize_round.sv
// Directed bench for step5_normalize_round: rounding/packing vectors,
// exception cases, backpressure ordering and mid-flight reset.
module tb_step5_normalize_round;

   logic        clock = 1'b0;
   logic        resetn;
   logic        in_valid, in_ready, in_sign, in_ov_sign;
   logic [9:0]  in_exp;
   logic [27:0] in_sum;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic        out_overflow, out_underflow, out_zero;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   step5_normalize_round dut (
      .clock        (clock),
      .resetn       (resetn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sign      (in_sign),
      .in_ov_sign   (in_ov_sign),
      .in_exp       (in_exp),
      .in_sum       (in_sum),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_overflow (out_overflow),
      .out_underflow(out_underflow),
      .out_zero     (out_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic [27:0] s, input logic [9:0] e, input logic sg, input logic ov);
      in_sum     = s;
      in_exp     = e;
      in_sign    = sg;
      in_ov_sign = ov;
   endtask

   // one beat with out_ready high; flags are {overflow, underflow, zero}
   task automatic run_one(input string tag, input logic [27:0] s, input logic [9:0] e,
                          input logic sg, input logic ov, input logic [31:0] er, input logic [2:0] ef);
      @(negedge clock);
      drive(s, e, sg, ov);
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      @(negedge clock);
      in_valid = 1'b0;
      chk({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
      @(negedge clock);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_result"}, out_result, er);
      chk({tag, "_flags"}, {29'd0, out_overflow, out_underflow, out_zero}, {29'd0, ef});
   endtask

   initial begin
      resetn    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(28'd0, 10'd0, 1'b0, 1'b0);
      repeat (2) @(negedge clock);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_result", out_result, 32'd0);
      chk("rst_flags", {29'd0, out_overflow, out_underflow, out_zero}, 32'd0);
      resetn = 1'b1;

      run_one("one",      28'h4000000, 10'd127, 1'b0, 1'b0, 32'h3F800000, 3'b000);
      run_one("carry",    28'h8000000, 10'd127, 1'b0, 1'b0, 32'h40000000, 3'b000);
      run_one("carry_neg",28'h8000000, 10'd127, 1'b1, 1'b0, 32'hC0000000, 3'b000);
      run_one("tie_even", 28'h4000004, 10'd127, 1'b0, 1'b0, 32'h3F800000, 3'b000);
      run_one("tie_odd",  28'h400000C, 10'd127, 1'b0, 1'b0, 32'h3F800002, 3'b000);
      run_one("carry_rne",28'h8000018, 10'd127, 1'b0, 1'b0, 32'h40000002, 3'b000);
      run_one("rnd_cout", 28'h7FFFFFC, 10'd127, 1'b0, 1'b0, 32'h40000000, 3'b000);
      run_one("lzc23",    28'h0000008, 10'd127, 1'b0, 1'b0, 32'h34000000, 3'b000);
      run_one("ovf",      28'h8000000, 10'd254, 1'b0, 1'b0, 32'h7F800000, 3'b100);
      run_one("ov_sign",  28'h1234567, 10'd100, 1'b1, 1'b1, 32'hFF800000, 3'b100);
      run_one("zero",     28'h0000000, 10'd0,   1'b0, 1'b0, 32'h00000000, 3'b001);
`ifdef STEP5_DENORM_EN
      run_one("tiny",     28'h4000000, 10'd0,   1'b0, 1'b0, 32'h00400000, 3'b000);
`else
      run_one("tiny",     28'h4000000, 10'd0,   1'b0, 1'b0, 32'h00000000, 3'b011);
`endif

      // backpressure: three back-to-back beats with the sink stalled
      @(negedge clock);
      out_ready = 1'b0;
      drive(28'h4000000, 10'd127, 1'b0, 1'b0);
      in_valid = 1'b1;
      @(negedge clock);
      chk("bp_rdy_after1", {31'd0, in_ready}, 32'd1);
      drive(28'h8000000, 10'd127, 1'b0, 1'b0);
      @(negedge clock);
      drive(28'h400000C, 10'd127, 1'b0, 1'b0);
      chk("bp_rdy_full", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold0", out_result, 32'h3F800000);
      @(negedge clock);
      chk("bp_rdy_full2", {31'd0, in_ready}, 32'd0);
      chk("bp_hold1", out_result, 32'h3F800000);
      out_ready = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      chk("bp_r1_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_r1", out_result, 32'h40000000);
      @(negedge clock);
      chk("bp_r2_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_r2", out_result, 32'h3F800002);
      @(negedge clock);
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // reset while both stages hold data
      drive(28'h8000000, 10'd127, 1'b1, 1'b0);
      in_valid = 1'b1;
      @(negedge clock);
      drive(28'h4000000, 10'd127, 1'b0, 1'b0);
      @(negedge clock);
      in_valid = 1'b0;
      chk("mf_pre_valid", {31'd0, out_valid}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("mf_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mf_rst_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clock);
      resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("mf_no_stale", {31'd0, out_valid}, 32'd0);
      end
      run_one("post_rst", 28'h8000000, 10'd127, 1'b1, 1'b0, 32'hC0000000, 3'b000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
